// File: rtl/ysyx_22040088_lsu_if.sv
// rtl/ysyx_22040088_lsu_if.sv - LSU request/grant/rvalid memory bus
interface ysyx_22040088_lsu_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [7:0]        bus_wstrb;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/ysyx_22040088_lsu.sv
// rtl/ysyx_22040088_lsu.sv - load/store unit with lane steering, extension and error detection
module ysyx_22040088_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_ena,
    input  logic              mem_wen,
    input  logic [3:0]        mem_mask,
    input  logic [1:0]        sel_memdata,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    ysyx_22040088_lsu_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] state;
    logic [2:0] off_q;
    logic [3:0] mask_q;
    logic       zext_q;
    logic       wen_q;

    logic       mask_onehot;
    logic       misaligned;
    logic [7:0] strb_base;
    logic [7:0] strb;
    logic [DATA_W-1:0] shifted_rd;
    logic [DATA_W-1:0] load_data;

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign bus.bus_req  = (state == REQ);

    // Size decode: only legal one-hot masks produce a nonzero byte pattern.
    always_comb begin
        mask_onehot = 1'b1;
        misaligned  = 1'b0;
        strb_base   = 8'h00;
        case (mem_mask)
            4'b0001: begin strb_base = 8'hFF; misaligned = (addr[2:0] != 3'd0); end
            4'b0010: begin strb_base = 8'h0F; misaligned = (addr[1:0] != 2'd0); end
            4'b0100: begin strb_base = 8'h03; misaligned = addr[0];             end
            4'b1000: begin strb_base = 8'h01; misaligned = 1'b0;                end
            default: mask_onehot = 1'b0;
        endcase
        strb = strb_base << addr[2:0];
    end

    always_comb begin
        shifted_rd = bus.bus_rdata >> {off_q, 3'b000};
        load_data  = '0;
        case (mask_q)
            4'b0001: load_data = shifted_rd;
            4'b0010: load_data = zext_q ? {32'd0, shifted_rd[31:0]}
                                        : {{32{shifted_rd[31]}}, shifted_rd[31:0]};
            4'b0100: load_data = zext_q ? {48'd0, shifted_rd[15:0]}
                                        : {{48{shifted_rd[15]}}, shifted_rd[15:0]};
            4'b1000: load_data = zext_q ? {56'd0, shifted_rd[7:0]}
                                        : {{56{shifted_rd[7]}}, shifted_rd[7:0]};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            off_q         <= 3'd0;
            mask_q        <= 4'd0;
            zext_q        <= 1'b0;
            wen_q         <= 1'b0;
            out_rdata     <= '0;
            out_err       <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_wstrb <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        off_q     <= addr[2:0];
                        mask_q    <= mem_mask;
                        zext_q    <= sel_memdata[1];
                        wen_q     <= mem_wen;
                        out_rdata <= '0;
                        if (!mem_ena) begin
                            out_err <= 1'b0;
                            state   <= DONE;
                        end else if (!mask_onehot || misaligned) begin
                            out_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            out_err       <= 1'b0;
                            bus.bus_we    <= mem_wen;
                            bus.bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
                            bus.bus_wdata <= wdata << {addr[2:0], 3'b000};
                            bus.bus_wstrb <= mem_wen ? strb : 8'h00;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Bus fields stay latched until grant; rvalid has no meaning here.
                    if (bus.bus_gnt) begin
                        bus.bus_we    <= 1'b0;
                        bus.bus_wstrb <= 8'h00;
                        state         <= wen_q ? DONE : RESP;
                    end
                end
                RESP: begin
                    if (bus.bus_rvalid) begin
                        out_rdata <= load_data;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
